aud_player: RTL

AUD_PLAYER -- requirements
Module: aud_player

---
 rtl/aud_player.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/aud_player.sv
// ---------------------------------------------------------------------------
// aud_player -- serialises 16-bit PCM samples onto a codec DAC data line.
//
// One sample is held in a holding register filled by a simple request/ack
// handshake with the upstream DSP stage. Each left frame (falling edge of
// i_daclrck) shifts the held word out MSB first over 16 bit-clock cycles.
// The right frame either repeats that word (stereo duplicate build) or
// drives zeros (mono build).
//
// Handshake: the DSP stage holds i_en=1 with i_dac_data valid. A sample is
// taken in any cycle where i_en=1 and o_ack=0; o_ack then pulses for exactly
// the following cycle, so a held request is taken at most every other cycle.
//
// Build option: define AUD_PLAYER_STEREO_DUP_EN to retransmit the left word
// in the right frame; leave it undefined for left-only mono output.
//
// Ports:
//   i_clk         codec bit clock, rising-edge active
//   i_rst_n       asynchronous active-low reset
//   i_daclrck     DAC left/right clock (0 = left frame, 1 = right frame)
//   i_en          sample-valid request from the DSP stage
//   i_dac_data    signed 16-bit PCM sample, valid while i_en=1
//   o_ack         one-cycle acceptance pulse
//   o_aud_dacdat  registered serial DAC data, MSB first
//   o_underflow   sticky: a left frame replayed a stale sample
//   o_state       current FSM state (0 IDLE, 1 WAIT_EDGE, 2 SEND_L, 3 SEND_R)
// ---------------------------------------------------------------------------
module aud_player (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_daclrck,
  input  logic        i_en,
  input  logic [15:0] i_dac_data,
  output logic        o_ack,
  output logic        o_aud_dacdat,
  output logic        o_underflow,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    SEND_L    = 2'd2,
    SEND_R    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        lrck_d;
  logic [15:0] hold_data;
  logic        hold_new;
  logic        first_frame;
  logic [15:0] shift_reg;
  logic [3:0]  bit_cnt;
`ifdef AUD_PLAYER_STEREO_DUP_EN
  logic [15:0] last_word;
`endif

  logic fall_edge;
  logic rise_edge;
  logic accept;
  logic load_l;
  logic load_r;
  logic shift_en;

  assign fall_edge = lrck_d & ~i_daclrck;
  assign rise_edge = ~lrck_d & i_daclrck;
  assign accept    = i_en & ~o_ack;
  assign o_state   = state;

  // Any lrck edge outside IDLE starts a new frame, even mid-word: a short
  // frame simply abandons the rest of the word in flight.
  always_comb begin
    state_nxt = state;
    load_l    = 1'b0;
    load_r    = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = WAIT_EDGE;
      end
      default: begin
        if (fall_edge) begin
          state_nxt = SEND_L;
          load_l    = 1'b1;
        end else if (rise_edge) begin
          state_nxt = SEND_R;
          load_r    = 1'b1;
        end else if (state != WAIT_EDGE) begin
          shift_en = 1'b1;
          if (bit_cnt == 4'd15) state_nxt = WAIT_EDGE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath. The word's MSB is registered straight onto the output at the
  // edge-detect clock, so shift_reg holds the remaining bits pre-shifted and
  // bit_cnt counts bits already on the wire (0..15) for the current word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrck_d       <= 1'b0;
      o_ack        <= 1'b0;
      hold_data    <= 16'h0000;
      hold_new     <= 1'b0;
      first_frame  <= 1'b0;
      shift_reg    <= 16'h0000;
      bit_cnt      <= 4'd0;
      o_aud_dacdat <= 1'b0;
      o_underflow  <= 1'b0;
`ifdef AUD_PLAYER_STEREO_DUP_EN
      last_word    <= 16'h0000;
`endif
    end else begin
      lrck_d <= i_daclrck;
      o_ack  <= accept;

      // A sample accepted on the same clock as a left edge lands after the
      // edge has already taken the old word, so it stays fresh for the next.
      if (accept) begin
        hold_data <= i_dac_data;
        hold_new  <= 1'b1;
      end else if (load_l) begin
        hold_new <= 1'b0;
      end

      if (state == IDLE && accept) first_frame <= 1'b1;

      if (load_l) begin
        shift_reg    <= {hold_data[14:0], 1'b0};
        o_aud_dacdat <= hold_data[15];
        bit_cnt      <= 4'd0;
        first_frame  <= 1'b0;
`ifdef AUD_PLAYER_STEREO_DUP_EN
        last_word    <= hold_data;
`endif
        if (!hold_new && !first_frame) o_underflow <= 1'b1;
      end else if (load_r) begin
`ifdef AUD_PLAYER_STEREO_DUP_EN
        shift_reg    <= {last_word[14:0], 1'b0};
        o_aud_dacdat <= last_word[15];
`else
        shift_reg    <= 16'h0000;
        o_aud_dacdat <= 1'b0;
`endif
        bit_cnt      <= 4'd0;
      end else if (shift_en) begin
        o_aud_dacdat <= (bit_cnt == 4'd15) ? 1'b0 : shift_reg[15];
        shift_reg    <= {shift_reg[14:0], 1'b0};
        bit_cnt      <= bit_cnt + 4'd1;
      end else begin
        o_aud_dacdat <= 1'b0;
      end
    end
  end

endmodule
